fpu_wb_sequencer: RTL and testbench
===================================

FPU_WB_SEQUENCER -- requirements
Module: fpu_wb_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 63, maximum EXEC-state cycles spent waiting for unit_done; range 1..255.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 issue_valid  in  1  decoded FP operation presented.
REQ-005 issue_ready  out  1  sequencer accepts the operation this cycle.
REQ-006 op  in  4  FPU op code: 0000 add/sub, 0001 float-to-int, 0010 int-to-float, 0011 mul, 0100 compare, 0101 min/max, 0110 classify, 1111 move/none.
REQ-007 rd  in  5  destination register index.
REQ-008 dst_int  in  1  destination is the integer file (1) or the FP file (0).
REQ-009 wr_en  in  1  the operation writes a destination.
REQ-010 move_data  in  32  source operand for op 1111 moves.
REQ-011 unit_start  out  1  one-cycle start pulse to the FPU datapath.
REQ-012 unit_op  out  4  latched op code driven to the datapath.
REQ-013 unit_done  in  1  datapath result valid.
REQ-014 unit_result  in  32  datapath result.
REQ-015 wb_valid  out  1  writeback request.
REQ-016 wb_ready  in  1  register file accepts the writeback.
REQ-017 wb_data  out  32  writeback data.
REQ-018 wb_rd  out  5  writeback index.
REQ-019 wb_freg  out  1  write the FP register file.
REQ-020 wb_ireg  out  1  write the integer register file.
REQ-021 stall  out  1  hold the upstream pipeline.
REQ-022 timeout_err  out  1  sticky datapath-timeout flag.

Function
REQ-023 The FSM SHALL have the states IDLE, EXEC and WB.
REQ-024 issue_ready SHALL be 1 only in IDLE; stall SHALL equal (state != IDLE) OR (issue_valid AND state == IDLE AND op != 1111).
REQ-025 On acceptance the sequencer SHALL latch op, rd, dst_int, wr_en and move_data.
REQ-026 Accepted op 1111 with wr_en=1: go to WB next cycle; wb_data = latched move_data; no unit_start.
REQ-027 Accepted op 1111 with wr_en=0: treat as a NOP; stay in IDLE; no outputs asserted.
REQ-028 Accepted op != 1111: assert unit_start for exactly the acceptance cycle, with unit_op valid that cycle; state -> EXEC.
REQ-029 In EXEC, unit_done=1: capture unit_result, clear the cycle counter, then go to WB if wr_en, else IDLE.
REQ-030 unit_done SHALL be ignored outside EXEC.
REQ-031 In WB: wb_valid=1; wb_data, wb_rd, wb_freg=!dst_int and wb_ireg=dst_int held stable until wb_ready=1; then state -> IDLE.
REQ-032 Integer destination with rd=0: wb_ireg SHALL be forced 0 while the WB handshake still completes normally.
REQ-033 Minimum latency, issue to wb_valid: 1 cycle for a move; N+1 cycles for a unit op where unit_done rises N cycles after unit_start.
REQ-034 A new issue SHALL NOT be accepted in the cycle WB completes; the earliest next acceptance is the following cycle.
REQ-035 issue_valid SHALL be ignored while not in IDLE, and no latched field may change.

Reset
REQ-036 rst=1 at any time, including mid-EXEC or mid-WB, SHALL force state IDLE immediately.
REQ-037 Under reset, issue_ready=1 and the following are all 0: unit_start, unit_op, wb_valid, wb_data, wb_rd, wb_freg, wb_ireg, stall, timeout_err, cycle counter.
REQ-038 A unit_done arriving after a mid-operation reset SHALL be ignored.

Configuration
REQ-039 Macro FPU_SEQ_TIMEOUT_EN, when defined:
- an 8-bit counter increments each EXEC cycle;
- on reaching TIMEOUT_CYCLES without unit_done, set timeout_err (sticky until rst), go to IDLE, and perform no writeback.
REQ-040 Macro FPU_SEQ_TIMEOUT_EN, when undefined: no counter is built, EXEC waits indefinitely, and timeout_err is tied to 0.

Verification
REQ-041 Issue op 0011, rd=5, dst_int=0, wr_en=1; unit_done 3 cycles after the start pulse with result 0x40400000 -> wb_valid on cycle 4, wb_freg=1, wb_rd=5, wb_data=0x40400000.
REQ-042 Issue op 1111, dst_int=1, rd=7, move_data=0xDEADBEEF; wb_ready held low 2 cycles -> wb_valid and all wb_* fields held stable 3 cycles, then state returns to IDLE.
REQ-043 Issue op 0100, dst_int=1, rd=0 -> WB completes with wb_ireg=0; the next issue is accepted the following cycle.
REQ-044 Assert rst during EXEC, then pulse unit_done -> state IDLE, no wb_valid, issue_ready=1.
REQ-045 With FPU_SEQ_TIMEOUT_EN defined and TIMEOUT_CYCLES=4, never assert unit_done -> timeout_err=1 after 4 EXEC cycles, state IDLE, no writeback.
REQ-046 Hold issue_valid with new fields during EXEC -> issue_ready=0, latched fields unchanged, stall=1.

Source files
------------

// File: rtl/fpu_wb_sequencer.sv
// rtl/fpu_wb_sequencer.sv - FPU issue/execute/writeback sequencer.
// Optional datapath timeout is built when FPU_SEQ_TIMEOUT_EN is defined.
module fpu_wb_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [3:0]  op,
  input  logic [4:0]  rd,
  input  logic        dst_int,
  input  logic        wr_en,
  input  logic [31:0] move_data,
  output logic        unit_start,
  output logic [3:0]  unit_op,
  input  logic        unit_done,
  input  logic [31:0] unit_result,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_freg,
  output logic        wb_ireg,
  output logic        stall,
  output logic        timeout_err
);

  localparam logic [3:0] OP_MOVE = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic        dst_int_q, dst_int_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] data_q, data_d;
  logic        accept;
  logic        in_wb;

`ifdef FPU_SEQ_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0]  cnt_q, cnt_d;
  logic        timeout_err_q, timeout_err_d;
`endif

  assign accept = !rst && (state_q == S_IDLE) && issue_valid;
  assign in_wb  = (state_q == S_WB);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    dst_int_d = dst_int_q;
    wr_en_d   = wr_en_q;
    data_d    = data_q;
`ifdef FPU_SEQ_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (issue_valid) begin
          op_d      = op;
          rd_d      = rd;
          dst_int_d = dst_int;
          wr_en_d   = wr_en;
          data_d    = move_data;
          if (op == OP_MOVE) begin
            state_d = wr_en ? S_WB : S_IDLE;
          end else begin
            state_d = S_EXEC;
          end
`ifdef FPU_SEQ_TIMEOUT_EN
          cnt_d = 8'd0;
`endif
        end
      end
      S_EXEC: begin
        if (unit_done) begin
          data_d  = unit_result;
          state_d = wr_en_q ? S_WB : S_IDLE;
`ifdef FPU_SEQ_TIMEOUT_EN
          cnt_d = 8'd0;
        end else if (cnt_q + 8'd1 >= TIMEOUT_LIMIT) begin
          // Abandon the operation: no writeback, flag stays set until reset.
          timeout_err_d = 1'b1;
          cnt_d         = 8'd0;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      S_WB: begin
        if (wb_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= 4'd0;
      rd_q      <= 5'd0;
      dst_int_q <= 1'b0;
      wr_en_q   <= 1'b0;
      data_q    <= 32'd0;
`ifdef FPU_SEQ_TIMEOUT_EN
      cnt_q         <= 8'd0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      dst_int_q <= dst_int_d;
      wr_en_q   <= wr_en_d;
      data_q    <= data_d;
`ifdef FPU_SEQ_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign issue_ready = (state_q == S_IDLE);
  assign unit_start  = accept && (op != OP_MOVE);
  // The datapath sees the incoming op during the acceptance cycle, the latched one afterwards.
  assign unit_op     = rst ? 4'd0 : (accept ? op : op_q);
  assign stall       = !rst && ((state_q != S_IDLE) || (issue_valid && (op != OP_MOVE)));
  assign wb_valid    = in_wb;
  assign wb_data     = in_wb ? data_q : 32'd0;
  assign wb_rd       = in_wb ? rd_q : 5'd0;
  assign wb_freg     = in_wb && !dst_int_q;
  assign wb_ireg     = in_wb && dst_int_q && (rd_q != 5'd0);

`ifdef FPU_SEQ_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_wb_sequencer.sv
// tb/tb_fpu_wb_sequencer.sv - self-checking bench for fpu_wb_sequencer.
// Transaction-level model checked every cycle, plus directed literal scenarios.
module tb_fpu_wb_sequencer;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [4:0]  rd = 5'd0;
  logic        dst_int = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] move_data = 32'd0;
  logic        unit_done = 1'b0;
  logic [31:0] unit_result = 32'd0;
  logic        wb_ready = 1'b0;
  logic        issue_ready, unit_start, wb_valid, wb_freg, wb_ireg, stall, timeout_err;
  logic [3:0]  unit_op;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_wb_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .op(op), .rd(rd), .dst_int(dst_int), .wr_en(wr_en), .move_data(move_data),
    .unit_start(unit_start), .unit_op(unit_op), .unit_done(unit_done),
    .unit_result(unit_result), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_freg(wb_freg), .wb_ireg(wb_ireg),
    .stall(stall), .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0 = nothing pending, 1 = waiting on the datapath, 2 = writeback offered.
  int          m_mode = 0;
  int          m_cnt = 0;
  logic [3:0]  m_op = 4'd0;
  logic [4:0]  m_rd = 5'd0;
  logic        m_dst = 1'b0;
  logic        m_wr = 1'b0;
  logic [31:0] m_data = 32'd0;
  logic        m_err = 1'b0;
  bit          m_live = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0; m_cnt <= 0; m_op <= 4'd0; m_rd <= 5'd0; m_dst <= 1'b0;
      m_wr <= 1'b0; m_data <= 32'd0; m_err <= 1'b0; m_live <= 1'b1;
    end else begin
      case (m_mode)
        0: if (issue_valid) begin
          m_op <= op; m_rd <= rd; m_dst <= dst_int; m_wr <= wr_en;
          if (op == 4'hF) begin
            m_data <= move_data;
            m_mode <= wr_en ? 2 : 0;
          end else begin
            m_mode <= 1;
            m_cnt  <= 0;
          end
        end
        1: if (unit_done) begin
          m_data <= unit_result;
          m_mode <= m_wr ? 2 : 0;
        end
`ifdef FPU_SEQ_TIMEOUT_EN
        else if (m_cnt + 1 >= TO) begin
          m_err  <= 1'b1;
          m_mode <= 0;
        end else begin
          m_cnt <= m_cnt + 1;
        end
`endif
        default: if (wb_ready) m_mode <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst || m_live) begin
      logic acc, inwb;
      acc  = !rst && (m_mode == 0) && issue_valid;
      inwb = !rst && (m_mode == 2);
      chk("m_issue_ready", issue_ready, (rst || m_mode == 0));
      chk("m_unit_start", unit_start, acc && (op != 4'hF));
      chk("m_unit_op", unit_op, rst ? 4'd0 : (acc ? op : m_op));
      chk("m_stall", stall, !rst && ((m_mode != 0) || (issue_valid && op != 4'hF)));
      chk("m_wb_valid", wb_valid, inwb);
      chk("m_wb_data", wb_data, inwb ? m_data : 32'd0);
      chk("m_wb_rd", wb_rd, inwb ? m_rd : 5'd0);
      chk("m_wb_freg", wb_freg, inwb && !m_dst);
      chk("m_wb_ireg", wb_ireg, inwb && m_dst && (m_rd != 5'd0));
      chk("m_timeout_err", timeout_err, rst ? 1'b0 : m_err);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] o, input logic [4:0] r, input logic d,
                       input logic w, input logic [31:0] md);
    issue_valid = 1'b1; op = o; rd = r; dst_int = d; wr_en = w; move_data = md;
  endtask

  logic [3:0] ops [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hF};

  initial begin
    // Reset, with an op presented to confirm it is not started
    cyc();
    issue(4'h3, 5'd1, 1'b0, 1'b1, 32'd0);
    smp();
    chk("rst_ready", issue_ready, 1); chk("rst_start", unit_start, 0);
    chk("rst_stall", stall, 0); chk("rst_wbv", wb_valid, 0);
    chk("rst_uop", unit_op, 0); chk("rst_err", timeout_err, 0);
    cyc(); rst = 1'b0; issue_valid = 1'b0;

    // Multiply, done 3 cycles after start, writeback on cycle 4
    cyc(); issue(4'h3, 5'd5, 1'b0, 1'b1, 32'd0);
    smp(); chk("mul_start", unit_start, 1); chk("mul_uop", unit_op, 3);
    cyc(); issue_valid = 1'b0;
    cyc();
    cyc(); unit_done = 1'b1; unit_result = 32'h40400000;
    smp(); chk("mul_wb_early", wb_valid, 0);
    cyc(); unit_done = 1'b0; wb_ready = 1'b1;
    smp(); chk("mul_wbv", wb_valid, 1); chk("mul_freg", wb_freg, 1);
    chk("mul_ireg", wb_ireg, 0); chk("mul_rd", wb_rd, 5); chk("mul_data", wb_data, 32'h40400000);
    cyc(); wb_ready = 1'b0;
    smp(); chk("mul_idle", issue_ready, 1);

    // Move with writeback back-pressure for 2 cycles
    cyc(); issue(4'hF, 5'd7, 1'b1, 1'b1, 32'hDEADBEEF);
    smp(); chk("mv_start", unit_start, 0); chk("mv_stall", stall, 0);
    cyc(); issue_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) wb_ready = 1'b1;
      smp();
      chk("mv_wbv", wb_valid, 1); chk("mv_data", wb_data, 32'hDEADBEEF);
      chk("mv_rd", wb_rd, 7); chk("mv_ireg", wb_ireg, 1); chk("mv_freg", wb_freg, 0);
      cyc();
    end
    wb_ready = 1'b0;
    smp(); chk("mv_done_wbv", wb_valid, 0); chk("mv_done_ready", issue_ready, 1);

    // Compare to x0, then back-to-back issue and a NOP move
    cyc(); issue(4'h4, 5'd0, 1'b1, 1'b1, 32'd0);
    cyc(); issue_valid = 1'b0; unit_done = 1'b1; unit_result = 32'd1;
    cyc(); unit_done = 1'b0; wb_ready = 1'b1; issue(4'hF, 5'd3, 1'b0, 1'b1, 32'h1234);
    smp(); chk("x0_wbv", wb_valid, 1); chk("x0_ireg", wb_ireg, 0);
    chk("x0_freg", wb_freg, 0); chk("x0_no_accept", issue_ready, 0);
    cyc(); wb_ready = 1'b0;
    smp(); chk("x0_next_ready", issue_ready, 1);
    cyc(); issue_valid = 1'b0;
    smp(); chk("x0_next_wbv", wb_valid, 1); chk("x0_next_data", wb_data, 32'h1234);
    cyc(); wb_ready = 1'b1;
    cyc(); wb_ready = 1'b0; issue(4'hF, 5'd2, 1'b0, 1'b0, 32'h55);
    smp(); chk("nop_start", unit_start, 0); chk("nop_stall", stall, 0);
    cyc(); issue_valid = 1'b0;
    smp(); chk("nop_wbv", wb_valid, 0); chk("nop_ready", issue_ready, 1);

    // Reset mid-EXEC, then a late unit_done
    cyc(); issue(4'h0, 5'd10, 1'b0, 1'b1, 32'd0);
    cyc(); issue_valid = 1'b0;
    cyc(); rst = 1'b1;
    smp(); chk("mid_rst_ready", issue_ready, 1); chk("mid_rst_stall", stall, 0);
    cyc(); rst = 1'b0; unit_done = 1'b1; unit_result = 32'd77;
    smp(); chk("late_done_wbv", wb_valid, 0); chk("late_done_ready", issue_ready, 1);
    cyc(); unit_done = 1'b0;
    smp(); chk("late_done_wbv2", wb_valid, 0);

    // Issue held during EXEC must not disturb the latched fields
    cyc(); issue(4'h3, 5'd9, 1'b0, 1'b1, 32'h11);
    cyc(); issue(4'h1, 5'd20, 1'b1, 1'b1, 32'h22);
    smp(); chk("hold_ready", issue_ready, 0); chk("hold_stall", stall, 1);
    chk("hold_start", unit_start, 0); chk("hold_uop", unit_op, 3);
    cyc(); issue_valid = 1'b0; unit_done = 1'b1; unit_result = 32'hABCD0123;
    cyc(); unit_done = 1'b0; wb_ready = 1'b1;
    smp(); chk("hold_rd", wb_rd, 9); chk("hold_freg", wb_freg, 1);
    chk("hold_ireg", wb_ireg, 0); chk("hold_data", wb_data, 32'hABCD0123);
    cyc(); wb_ready = 1'b0;

`ifdef FPU_SEQ_TIMEOUT_EN
    cyc(); issue(4'h3, 5'd4, 1'b0, 1'b1, 32'd0);
    cyc(); issue_valid = 1'b0;
    cyc(); cyc(); cyc();
    smp(); chk("to_before", timeout_err, 0); chk("to_exec_ready", issue_ready, 0);
    cyc();
    smp(); chk("to_err", timeout_err, 1); chk("to_ready", issue_ready, 1); chk("to_wbv", wb_valid, 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst         = ($urandom_range(0, 149) == 0);
      issue_valid = 1'($urandom_range(0, 1));
      op          = ops[$urandom_range(0, 7)];
      rd          = 5'($urandom);
      dst_int     = 1'($urandom_range(0, 1));
      wr_en       = ($urandom_range(0, 3) != 0);
      move_data   = $urandom;
      unit_done   = ($urandom_range(0, 2) == 0);
      unit_result = $urandom;
      wb_ready    = 1'($urandom_range(0, 1));
    end
    cyc(); rst = 1'b0; issue_valid = 1'b0;
    smp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
